// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : FIFO store buffer between the MEM pipeline register and the data
//            memory write port, with load read-after-write hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_bits,
    output logic        st_ready,
    output logic        st_err,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        dm_wr,
    output logic [1:0]  dm_wr_bits,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_data,
    output logic        empty,
    output logic        full
);

    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [1:0]  c_BITS_BAD  = 2'b11;

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [1:0]       r_bits [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_st_err;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;
    logic [1:0]       w_unused_ld_lsb;

    // Byte offset within the word is irrelevant to the hazard compare.
    assign w_unused_ld_lsb = ld_addr[1:0];

    assign st_ready = (r_count < c_DEPTH_CNT);
    assign full     = (r_count == c_DEPTH_CNT);
    assign empty    = (r_count == '0);
    assign st_err   = r_st_err;

    assign w_push = st_valid & st_ready & (st_bits != c_BITS_BAD) & ~rst;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_hit[gi] = r_valid[gi] & (r_addr[gi][31:2] == ld_addr[31:2]);
        end
    endgenerate

    assign ld_hazard = ld_valid & (|w_hit);

    // A hazarded load yields the port so the blocking store can drain; a reset
    // cycle never strobes memory so no pending store commits partially.
    assign w_pop = ~rst & (r_count != '0) & (~ld_valid | ld_hazard);

    assign dm_wr      = w_pop;
    assign dm_addr    = r_addr[r_rd_ptr];
    assign dm_data    = r_data[r_rd_ptr];
    assign dm_wr_bits = r_bits[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_st_err <= 1'b0;
        end else begin
            r_st_err <= st_valid & (st_bits == c_BITS_BAD);
            if (w_push) begin
                r_wr_ptr           <= r_wr_ptr + AW'(1);
                r_valid[r_wr_ptr]  <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr           <= r_rd_ptr + AW'(1);
                r_valid[r_rd_ptr]  <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; r_valid qualifies every entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
            r_bits[r_wr_ptr] <= st_bits;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Self-checking bench for store_buffer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_bits;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        dm_wr;
    logic [1:0]  dm_wr_bits;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic        empty;
    logic        full;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  bits;
    } entry_t;

    entry_t model_q[$];
    logic   exp_err = 1'b0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_bits(st_bits),
        .st_ready(st_ready), .st_err(st_err),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .dm_wr(dm_wr), .dm_wr_bits(dm_wr_bits), .dm_addr(dm_addr), .dm_data(dm_data),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_hazard();
        foreach (model_q[i])
            if (model_q[i].addr[31:2] == ld_addr[31:2]) return ld_valid;
        return 1'b0;
    endfunction

    function automatic logic m_drain();
        return !rst && (model_q.size() != 0) && (!ld_valid || m_hazard());
    endfunction

    function automatic logic m_push();
        return !rst && st_valid && (model_q.size() < DEPTH) && (st_bits != 2'b11);
    endfunction

    // Drive inputs away from the active edge, then let combinational outputs settle.
    task automatic apply(input logic r, input logic sv, input logic [31:0] sa,
                         input logic [31:0] sd, input logic [1:0] sb,
                         input logic lv, input logic [31:0] la);
        @(negedge clk);
        rst = r; st_valid = sv; st_addr = sa; st_data = sd; st_bits = sb;
        ld_valid = lv; ld_addr = la;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    // Cross the active edge and update the model with what memory/buffer saw.
    task automatic advance();
        logic   d, p, e;
        entry_t ne;
        d  = m_drain();
        p  = m_push();
        e  = !rst && st_valid && (st_bits == 2'b11);
        ne = '{addr: st_addr, data: st_data, bits: st_bits};
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_err = 1'b0;
        end else begin
            if (d) void'(model_q.pop_front());
            if (p) model_q.push_back(ne);
            exp_err = e;
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2 && model_q.size() != 0; i++) begin
            idle();
            advance();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply(1'b1, 1'b1, 32'h10, 32'h1111_1111, 2'b11, 1'b0, 32'h0);
        advance();
        apply(1'b1, 1'b1, 32'h10, 32'h1111_1111, 2'b00, 1'b0, 32'h0);
        advance();
        idle();
        n_chk++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", st_ready); end
        n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_chk++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_chk++; if (dm_wr !== 1'b0) begin n_err++; $display("FAIL reset_dm_wr: got %b want 0", dm_wr); end
        n_chk++; if (st_err !== 1'b0) begin n_err++; $display("FAIL reset_st_err: got %b want 0", st_err); end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h10);
        n_chk++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b want 0", ld_hazard); end
        advance();
    endtask

    task automatic test_single_sw();
        apply(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0);
        n_chk++; if (dm_wr !== 1'b0) begin n_err++; $display("FAIL sw_no_bypass: got %b want 0", dm_wr); end
        advance();
        idle();
        n_chk++; if (dm_wr !== 1'b1) begin n_err++; $display("FAIL sw_dm_wr: got %b want 1", dm_wr); end
        n_chk++; if (dm_addr !== 32'h10) begin n_err++; $display("FAIL sw_dm_addr: got %h want 00000010", dm_addr); end
        n_chk++; if (dm_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_dm_data: got %h want deadbeef", dm_data); end
        n_chk++; if (dm_wr_bits !== 2'b00) begin n_err++; $display("FAIL sw_dm_bits: got %b want 00", dm_wr_bits); end
        advance();
        idle();
        n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL sw_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 32'h200 + i, 32'hA0 + i, 2'b10, 1'b1, 32'h100);
            n_chk++; if (st_ready !== (i < 4)) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want %b", i, st_ready, i < 4); end
            n_chk++; if (full !== (i == 4)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 4); end
            n_chk++; if (dm_wr !== 1'b0) begin n_err++; $display("FAIL fill_dm_wr[%0d]: got %b want 0", i, dm_wr); end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            n_chk++; if (dm_wr !== 1'b1) begin n_err++; $display("FAIL fill_drain_wr[%0d]: got %b want 1", i, dm_wr); end
            n_chk++; if (dm_addr !== 32'h200 + i) begin n_err++; $display("FAIL fill_drain_addr[%0d]: got %h want %h", i, dm_addr, 32'h200 + i); end
            n_chk++; if (dm_data !== 32'hA0 + i || dm_wr_bits !== 2'b10) begin n_err++; $display("FAIL fill_drain_data[%0d]: got %h/%b want %h/10", i, dm_data, dm_wr_bits, 32'hA0 + i); end
            advance();
        end
        idle();
        n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty: got %b want 1", empty); end
    endtask

    task automatic test_raw_hazard();
        apply(1'b0, 1'b1, 32'h22, 32'h0000_1234, 2'b01, 1'b1, 32'h100);
        advance();
        apply(1'b0, 1'b1, 32'h40, 32'h5555_AAAA, 2'b00, 1'b1, 32'h100);
        advance();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h20);
        n_chk++; if (ld_hazard !== 1'b1) begin n_err++; $display("FAIL raw_hazard: got %b want 1", ld_hazard); end
        n_chk++; if (dm_wr !== 1'b1) begin n_err++; $display("FAIL raw_drain_wr: got %b want 1", dm_wr); end
        n_chk++; if (dm_addr !== 32'h22 || dm_wr_bits !== 2'b01) begin n_err++; $display("FAIL raw_drain_head: got %h/%b want 00000022/01", dm_addr, dm_wr_bits); end
        advance();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h20);
        n_chk++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL raw_cleared: got %b want 0", ld_hazard); end
        n_chk++; if (dm_wr !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL raw_load_owns: got wr=%b empty=%b want 0/0", dm_wr, empty); end
        advance();
        idle();
        n_chk++; if (dm_addr !== 32'h40 || dm_wr !== 1'b1) begin n_err++; $display("FAIL raw_remaining: got %h wr=%b want 00000040 wr=1", dm_addr, dm_wr); end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 32'h400 + 4 * i, 32'hB000 + i, 2'b00, 1'b1, 32'hF00);
            advance();
        end
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b1, 32'h400 + 4 * (k + 2), 32'hB000 + k + 2, 2'b00, 1'b0, 32'h0);
            n_chk++; if (dm_wr !== 1'b1 || dm_addr !== 32'h400 + 4 * k) begin n_err++; $display("FAIL b2b_pop[%0d]: got wr=%b %h want wr=1 %h", k, dm_wr, dm_addr, 32'h400 + 4 * k); end
            n_chk++; if (dm_data !== 32'hB000 + k) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, dm_data, 32'hB000 + k); end
            n_chk++; if (st_ready !== 1'b1 || full !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL b2b_level[%0d]: got rdy=%b full=%b empty=%b want 1/0/0", k, st_ready, full, empty); end
            advance();
        end
        for (int i = 10; i < 12; i++) begin
            idle();
            n_chk++; if (dm_addr !== 32'h400 + 4 * i || dm_wr !== 1'b1) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h wr=%b want %h", i, dm_addr, dm_wr, 32'h400 + 4 * i); end
            advance();
        end
        idle();
        n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_illegal();
        apply(1'b0, 1'b1, 32'h80, 32'h1, 2'b11, 1'b0, 32'h0);
        n_chk++; if (st_err !== 1'b0) begin n_err++; $display("FAIL ill_err_early: got %b want 0", st_err); end
        advance();
        idle();
        n_chk++; if (st_err !== 1'b1) begin n_err++; $display("FAIL ill_err_pulse: got %b want 1", st_err); end
        n_chk++; if (empty !== 1'b1 || dm_wr !== 1'b0) begin n_err++; $display("FAIL ill_no_push: got empty=%b wr=%b want 1/0", empty, dm_wr); end
        advance();
        idle();
        n_chk++; if (st_err !== 1'b0) begin n_err++; $display("FAIL ill_err_one_cycle: got %b want 0", st_err); end
        advance();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 32'h300 + 4 * i, 32'hC0 + i, 2'b00, 1'b1, 32'hF00);
            advance();
        end
        apply(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
        n_chk++; if (dm_wr !== 1'b0) begin n_err++; $display("FAIL rmid_no_partial: got %b want 0", dm_wr); end
        advance();
        for (int i = 0; i < 4; i++) begin
            idle();
            n_chk++; if (empty !== 1'b1 || dm_wr !== 1'b0) begin n_err++; $display("FAIL rmid_discard[%0d]: got empty=%b wr=%b addr=%h want 1/0", i, empty, dm_wr, dm_addr); end
            advance();
        end
    endtask

    task automatic test_random();
        logic        r, sv, lv;
        logic [31:0] sa, la;
        logic [1:0]  sb;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 63) == 0);
            sv = $urandom_range(0, 1);
            lv = ($urandom_range(0, 2) == 0);
            sb = 2'($urandom_range(0, 3));
            sa = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            la = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            apply(r, sv, sa, $urandom, sb, lv, la);
            n_chk++; if (st_ready !== (model_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, st_ready, model_q.size() < DEPTH); end
            n_chk++; if (full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin n_err++; $display("FAIL rnd_level[%0d]: got full=%b empty=%b size=%0d", c, full, empty, model_q.size()); end
            n_chk++; if (ld_hazard !== m_hazard()) begin n_err++; $display("FAIL rnd_hazard[%0d]: got %b want %b", c, ld_hazard, m_hazard()); end
            n_chk++; if (dm_wr !== m_drain()) begin n_err++; $display("FAIL rnd_dm_wr[%0d]: got %b want %b", c, dm_wr, m_drain()); end
            n_chk++; if (st_err !== exp_err) begin n_err++; $display("FAIL rnd_st_err[%0d]: got %b want %b", c, st_err, exp_err); end
            if (m_drain()) begin
                n_chk++;
                if (dm_addr !== model_q[0].addr || dm_data !== model_q[0].data || dm_wr_bits !== model_q[0].bits) begin
                    n_err++;
                    $display("FAIL rnd_head[%0d]: got %h/%h/%b want %h/%h/%b", c, dm_addr, dm_data, dm_wr_bits,
                             model_q[0].addr, model_q[0].data, model_q[0].bits);
                end
            end
            advance();
        end
        drain_all();
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_bits = '0;
        ld_valid = 1'b0; ld_addr = '0;
        test_reset();
        test_single_sw();
        test_fill();
        test_raw_hazard();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
